// File: rtl/iir_tm_sequencer_if.sv
// iir_tm_sequencer_if: handshake, section-strobe and status bundle between the sequencer and its SOS datapath.
interface iir_tm_sequencer_if #(
    parameter int SW = 2,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic          x_load;
    logic          sec_en;
    logic [SW-1:0] sec_idx;
    logic [SW-1:0] coef_addr;
    logic          first_sec;
    logic          last_sec;
    logic          dp_ovf;
    logic          y_load;
    logic          out_valid;
    logic          out_ovf;
    logic          ovf_clr;
    logic          ovf_sticky;
    logic          busy;
    logic [CW-1:0] sample_cnt;

    modport master (
        input  in_valid, dp_ovf, ovf_clr,
        output in_ready, x_load, sec_en, sec_idx, coef_addr, first_sec, last_sec,
               y_load, out_valid, out_ovf, ovf_sticky, busy, sample_cnt
    );

    modport slave (
        output in_valid, dp_ovf, ovf_clr,
        input  in_ready, x_load, sec_en, sec_idx, coef_addr, first_sec, last_sec,
               y_load, out_valid, out_ovf, ovf_sticky, busy, sample_cnt
    );
endinterface

// File: rtl/iir_tm_sequencer.sv
// iir_tm_sequencer: steps one sample through NO_SOS time-shared second-order sections.
module iir_tm_sequencer #(
    parameter int NO_SOS = 4,
    parameter int SW     = 2,
    parameter int CW     = 16
) (
    input logic                 CLK,
    input logic                 RESET,
    iir_tm_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

    localparam logic [SW-1:0] K_LAST = SW'(NO_SOS - 1);

    state_t        state, state_nx;
    logic [SW-1:0] k;
    logic          acc;
    logic          sticky;
    logic          out_valid_q;
    logic          out_ovf_q;
    logic [CW-1:0] cnt;
    logic          run;
    logic          last;

    assign run  = state == RUN;
    assign last = run && k == K_LAST;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            k           <= '0;
            acc         <= 1'b0;
            sticky      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_nx;
            // k returns to 0 after the last section so sec_idx idles at 0
            k           <= (run && !last) ? k + 1'b1 : '0;
            acc         <= state == LOAD ? 1'b0 : run ? (acc | bus.dp_ovf) : acc;
            sticky      <= (run && bus.dp_ovf) ? 1'b1 : bus.ovf_clr ? 1'b0 : sticky;
            out_valid_q <= state == OUT;
            out_ovf_q   <= state == OUT && acc;
            cnt         <= state == OUT ? cnt + 1'b1 : cnt;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.x_load    = 1'b0;
        bus.sec_en    = 1'b0;
        bus.y_load    = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                state_nx     = bus.in_valid ? LOAD : IDLE;
            end
            LOAD: begin
                bus.x_load = 1'b1;
                state_nx   = RUN;
            end
            RUN: begin
                bus.sec_en = 1'b1;
                state_nx   = last ? OUT : RUN;
            end
            default: begin
                bus.y_load = 1'b1;
                state_nx   = IDLE;
            end
        endcase
    end

    assign bus.sec_idx    = k;
    assign bus.coef_addr  = k;
    assign bus.first_sec  = run && k == '0;
    assign bus.last_sec   = last;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.ovf_sticky = sticky;
    assign bus.busy       = state != IDLE;
    assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_iir_tm_sequencer.sv
// tb_iir_tm_sequencer: directed checks of the sequencer in 4-section, 3-bit-counter and 1-section builds.
module tb_iir_tm_sequencer;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    iir_tm_sequencer_if #(.SW(2), .CW(16)) b ();
    iir_tm_sequencer_if #(.SW(2), .CW(3))  bw ();
    iir_tm_sequencer_if #(.SW(1), .CW(16)) b1 ();

    iir_tm_sequencer #(.NO_SOS(4), .SW(2), .CW(16)) u_dut  (.CLK(CLK), .RESET(RESET), .bus(b));
    iir_tm_sequencer #(.NO_SOS(4), .SW(2), .CW(3))  u_dutw (.CLK(CLK), .RESET(RESET), .bus(bw));
    iir_tm_sequencer #(.NO_SOS(1), .SW(1), .CW(16)) u_dut1 (.CLK(CLK), .RESET(RESET), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // one full sample on the 4-section DUT; om/cm give dp_ovf/ovf_clr per section,
    // nz drives dp_ovf outside RUN, which must be ignored
    task automatic run_sample(input logic [3:0] om, input logic [3:0] cm, input logic nz);
        b.in_valid = 1'b1;
        b.dp_ovf   = nz;
        tick();
        b.in_valid = 1'b0;
        tick();
        for (int s = 0; s < 4; s++) begin
            b.dp_ovf  = om[s];
            b.ovf_clr = cm[s];
            tick();
        end
        b.dp_ovf  = nz;
        b.ovf_clr = 1'b0;
        tick();
        b.dp_ovf = 1'b0;
    endtask

    initial begin
        int seen;
        {b.in_valid, b.dp_ovf, b.ovf_clr}    = '0;
        {bw.in_valid, bw.dp_ovf, bw.ovf_clr} = '0;
        {b1.in_valid, b1.dp_ovf, b1.ovf_clr} = '0;
        tick();
        do_reset();
        chk("rst_in_ready", b.in_ready, 1);
        chk("rst_busy", b.busy, 0);
        chk("rst_strobes", {b.x_load, b.sec_en, b.y_load, b.first_sec, b.last_sec}, 0);
        chk("rst_idx", {b.sec_idx, b.coef_addr}, 0);
        chk("rst_out", {b.out_valid, b.out_ovf, b.ovf_sticky}, 0);
        chk("rst_cnt", b.sample_cnt, 0);

        // single sample timing
        b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
        chk("c1_strobes", {b.x_load, b.sec_en, b.y_load}, 3'b100);
        chk("c1_ready_busy", {b.in_ready, b.busy}, 2'b01);
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("run_strobes", {b.x_load, b.sec_en, b.y_load}, 3'b010);
            chk("run_idx", b.sec_idx, s);
            chk("run_addr", b.coef_addr, s);
            chk("run_first_last", {b.first_sec, b.last_sec}, {s == 0, s == 3});
        end
        tick();
        chk("c6_strobes", {b.x_load, b.sec_en, b.y_load, b.out_valid}, 4'b0010);
        tick();
        chk("c7_out_valid", {b.out_valid, b.out_ovf}, 2'b10);
        chk("c7_cnt", b.sample_cnt, 1);
        chk("c7_idle", {b.in_ready, b.busy, b.sec_idx}, 4'b1000);
        tick();
        chk("c8_pulse_end", b.out_valid, 0);

        // back-to-back samples with in_valid held high
        do_reset();
        b.in_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            chk("bb_in_ready", b.in_ready, i % 7 == 0);
            chk("bb_out_valid", b.out_valid, i == 7 || i == 14);
            tick();
        end
        b.in_valid = 1'b0;
        chk("bb_last_out", b.out_valid, 1);
        chk("bb_cnt", b.sample_cnt, 3);

        // overflow accumulation and sticky flag
        do_reset();
        run_sample(4'b0100, 4'b0000, 1'b0);
        chk("ovf_a", {b.out_valid, b.out_ovf, b.ovf_sticky}, 3'b111);
        tick();
        chk("ovf_a_pulse_end", {b.out_valid, b.out_ovf}, 2'b00);
        run_sample(4'b0000, 4'b0000, 1'b1);
        chk("ovf_b", {b.out_valid, b.out_ovf, b.ovf_sticky}, 3'b101);
        b.ovf_clr = 1'b1;
        tick();
        b.ovf_clr = 1'b0;
        chk("ovf_clr_idle", b.ovf_sticky, 0);
        run_sample(4'b0010, 4'b0010, 1'b0);
        chk("ovf_set_wins", {b.out_valid, b.out_ovf, b.ovf_sticky}, 3'b111);
        b.ovf_clr = 1'b1;
        tick();
        b.ovf_clr = 1'b0;
        run_sample(4'b0000, 4'b1000, 1'b1);
        chk("ovf_noise_ignored", {b.out_valid, b.out_ovf, b.ovf_sticky}, 3'b100);
        chk("ovf_cnt", b.sample_cnt, 4);

        // reset abandons a sample mid-run
        do_reset();
        b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
        tick();
        tick();
        chk("abort_idx", b.sec_idx, 1);
        do_reset();
        chk("abort_idle", {b.in_ready, b.busy, b.sec_en}, 3'b100);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            seen += int'(b.out_valid);
            tick();
        end
        chk("abort_no_out", seen, 0);
        chk("abort_cnt", b.sample_cnt, 0);

        // reset beats in_valid in the same cycle
        RESET = 1'b1;
        b.in_valid = 1'b1;
        b.ovf_clr = 1'b1;
        tick();
        RESET = 1'b0;
        b.in_valid = 1'b0;
        b.ovf_clr = 1'b0;
        chk("rst_prio", {b.busy, b.in_ready}, 2'b01);

        // 3-bit sample counter wrap
        do_reset();
        bw.in_valid = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            repeat (7) tick();
            chk("wrap_cnt", bw.sample_cnt, s % 8);
        end
        bw.in_valid = 1'b0;

        // single-section build
        do_reset();
        b1.in_valid = 1'b1;
        tick();
        b1.in_valid = 1'b0;
        chk("one_load", {b1.x_load, b1.sec_en, b1.y_load}, 3'b100);
        tick();
        chk("one_run", {b1.sec_en, b1.first_sec, b1.last_sec, b1.sec_idx}, 4'b1110);
        tick();
        chk("one_out", {b1.y_load, b1.sec_en, b1.out_valid}, 3'b100);
        tick();
        chk("one_valid", {b1.out_valid, b1.in_ready}, 2'b11);
        chk("one_cnt", b1.sample_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/iir_tm_sequencer.md
IIR_TM_SEQUENCER -- requirements
Module: iir_tm_sequencer

Interface
REQ-001 Parameter NO_SOS, default 4: number of second-order sections time-shared on one SOS datapath; legal range 1..2**SW.
REQ-002 Parameter SW, default 2: width of section index and coefficient address.
REQ-003 Parameter CW, default 16: width of the sample counter.
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  new input sample X present on the datapath input.
REQ-007 in_ready  out  1  sequencer can accept a sample this cycle.
REQ-008 x_load  out  1  datapath captures X into the section-0 input register.
REQ-009 sec_en  out  1  datapath computes one SOS this cycle.
REQ-010 sec_idx  out  SW  index of the section being computed.
REQ-011 coef_addr  out  SW  coefficient/scale ROM row for sec_idx; equals sec_idx.
REQ-012 first_sec, last_sec  out  1 each  sec_en cycle is section 0 / section NO_SOS-1.
REQ-013 dp_ovf  in  1  datapath overflow flag for the current section result.
REQ-014 y_load  out  1  datapath loads the last section result into output register Y.
REQ-015 out_valid  out  1  Y holds a new filtered sample (one-cycle pulse).
REQ-016 out_ovf  out  1  overflow occurred in some section of the sample reported by out_valid.
REQ-017 ovf_clr  in  1  clears ovf_sticky.
REQ-018 ovf_sticky  out  1  overflow seen since the last reset or clear.
REQ-019 busy  out  1  a sample is in flight.
REQ-020 sample_cnt  out  CW  number of samples completed, modulo 2**CW.

Function
REQ-021 FSM states: IDLE, LOAD, RUN, OUT.
REQ-022 IDLE: in_ready=1; in_valid=1 -> LOAD, else stay.
REQ-023 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored, with no queuing.
REQ-024 LOAD (1 cycle): x_load=1, section counter k cleared to 0, per-sample overflow accumulator cleared -> RUN.
REQ-025 RUN (NO_SOS cycles): sec_en=1, sec_idx=coef_addr=k, first_sec=(k==0), last_sec=(k==NO_SOS-1).
REQ-026 RUN: k increments each cycle; at k==NO_SOS-1 -> OUT, else stay; k never exceeds NO_SOS-1.
REQ-027 RUN: accumulator |= dp_ovf each cycle; dp_ovf outside RUN is ignored.
REQ-028 OUT (1 cycle): y_load=1; accumulator presented on out_ovf -> IDLE.
REQ-029 out_valid and out_ovf SHALL be registered and assert exactly one cycle after the OUT cycle; out_ovf SHALL be 0 whenever out_valid=0.
REQ-030 Latency: from the in_valid&in_ready edge to out_valid high is NO_SOS+3 cycles; minimum sample period is NO_SOS+3 cycles.
REQ-031 busy=1 in LOAD, RUN and OUT; busy=0 in IDLE.
REQ-032 sample_cnt increments on the edge that ends OUT, wrapping from 2**CW-1 to 0.
REQ-033 ovf_sticky is set by dp_ovf in RUN; ovf_clr clears it; when set and clear coincide, set wins.
REQ-034 NO_SOS=1: RUN lasts 1 cycle with first_sec=last_sec=1.
REQ-035 Strobes x_load, sec_en, y_load are mutually exclusive in every cycle.

Reset
REQ-036 RESET=1 at an edge forces IDLE, k=0, accumulator=0, ovf_sticky=0, sample_cnt=0, out_valid=out_ovf=0.
REQ-037 After the reset edge: in_ready=1; busy, x_load, sec_en, y_load, first_sec, last_sec=0; sec_idx=coef_addr=0.
REQ-038 RESET mid-sample (LOAD/RUN/OUT) abandons the sample; no out_valid is produced for it and sample_cnt is unchanged.
REQ-039 RESET has priority over in_valid and ovf_clr in the same cycle.

Verification
REQ-040 NO_SOS=4, single in_valid pulse -> x_load at cycle 1; sec_en cycles 2-5 with sec_idx 0,1,2,3; y_load at cycle 6; out_valid at cycle 7; sample_cnt=1.
REQ-041 in_valid held high for 3 samples -> accepts spaced exactly 7 cycles apart; in_ready=0 while busy; sample_cnt=3.
REQ-042 dp_ovf=1 only during sec_idx=2 -> out_ovf=1 with out_valid, ovf_sticky=1; next sample without dp_ovf -> out_ovf=0, ovf_sticky stays 1; ovf_clr together with dp_ovf -> sticky stays 1.
REQ-043 RESET asserted during sec_idx=1 -> next cycle IDLE, in_ready=1, no out_valid, sample_cnt unchanged at 0.
REQ-044 CW=3, 9 samples -> sample_cnt wraps 7->0->1.
REQ-045 NO_SOS=1 -> single sec_en cycle with first_sec=last_sec=1; out_valid 4 cycles after accept.
